// File: rtl/writeback_unit.sv
// writeback_unit: MEM/WB pipeline register, load-data extraction, result
// select and register-file write gating, with a two-state FSM that parks a
// load in WB until late memory data arrives.
// Optional feature macro: WB_RETIRE_CNT_EN (retired-instruction counter).
module writeback_unit #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              ValidM,
  input  logic              RegWriteM,
  input  logic [1:0]        ResultSrcM,
  input  logic [1:0]        LoadSizeM,
  input  logic              LoadUnsM,
  input  logic [REG_AW-1:0] RdM,
  input  logic [DATA_W-1:0] ALU_ResultM,
  input  logic [DATA_W-1:0] ReadDataM,
  input  logic [DATA_W-1:0] PCPlus4M,
  input  logic [DATA_W-1:0] ImmExtM,
  input  logic              data_ready_i,
  input  logic [DATA_W-1:0] ReadDataLate_i,
  output logic              RegWriteW,
  output logic [REG_AW-1:0] RdW,
  output logic [DATA_W-1:0] ResultW,
  output logic              ValidW,
  output logic              busy_o,
  output logic              misalign_o,
  output logic [CNT_W-1:0]  retired_cnt_o
);

  typedef enum logic {S_RUN, S_WAIT} state_t;

  state_t              state_q, state_d;
  logic                valid_q, valid_d;
  logic                reg_write_q, reg_write_d;
  logic [1:0]          result_src_q, result_src_d;
  logic [1:0]          load_size_q, load_size_d;
  logic                load_uns_q, load_uns_d;
  logic [REG_AW-1:0]   rd_q, rd_d;
  logic [DATA_W-1:0]   alu_q, alu_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [DATA_W-1:0]   pc4_q, pc4_d;
  logic [DATA_W-1:0]   imm_q, imm_d;

  logic [1:0]          offset;
  logic                is_load;
  logic                misalign_det;
  logic [7:0]          byte_lane;
  logic [15:0]         half_lane;
  logic [DATA_W-1:0]   load_val;

  // Next-state for the MEM/WB fields and FSM: flush beats everything, WAIT only
  // listens for late data, otherwise stall holds and a normal edge captures.
  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    reg_write_d  = reg_write_q;
    result_src_d = result_src_q;
    load_size_d  = load_size_q;
    load_uns_d   = load_uns_q;
    rd_d         = rd_q;
    alu_d        = alu_q;
    rdata_d      = rdata_q;
    pc4_d        = pc4_q;
    imm_d        = imm_q;
    if (flush_i) begin
      state_d      = S_RUN;
      valid_d      = 1'b0;
      reg_write_d  = 1'b0;
      result_src_d = 2'b00;
      load_size_d  = 2'b00;
      load_uns_d   = 1'b0;
      rd_d         = '0;
      alu_d        = '0;
      rdata_d      = '0;
      pc4_d        = '0;
      imm_d        = '0;
    end else if (state_q == S_WAIT) begin
      if (data_ready_i) begin
        rdata_d = ReadDataLate_i;
        state_d = S_RUN;
      end
    end else if (!stall_i) begin
      valid_d      = ValidM;
      reg_write_d  = RegWriteM;
      result_src_d = ResultSrcM;
      load_size_d  = LoadSizeM;
      load_uns_d   = LoadUnsM;
      rd_d         = RdM;
      alu_d        = ALU_ResultM;
      rdata_d      = ReadDataM;
      pc4_d        = PCPlus4M;
      imm_d        = ImmExtM;
      if (ValidM && (ResultSrcM == 2'b01) && !data_ready_i) begin
        state_d = S_WAIT;
      end
    end
  end

  // MEM/WB register and FSM state flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_RUN;
      valid_q      <= 1'b0;
      reg_write_q  <= 1'b0;
      result_src_q <= 2'b00;
      load_size_q  <= 2'b00;
      load_uns_q   <= 1'b0;
      rd_q         <= '0;
      alu_q        <= '0;
      rdata_q      <= '0;
      pc4_q        <= '0;
      imm_q        <= '0;
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      reg_write_q  <= reg_write_d;
      result_src_q <= result_src_d;
      load_size_q  <= load_size_d;
      load_uns_q   <= load_uns_d;
      rd_q         <= rd_d;
      alu_q        <= alu_d;
      rdata_q      <= rdata_d;
      pc4_q        <= pc4_d;
      imm_q        <= imm_d;
    end
  end

  // Load lane extraction, extension and misalignment detection.
  always_comb begin
    offset    = alu_q[1:0];
    is_load   = (result_src_q == 2'b01);
    half_lane = offset[1] ? rdata_q[31:16] : rdata_q[15:0];
    case (offset)
      2'd0:    byte_lane = rdata_q[7:0];
      2'd1:    byte_lane = rdata_q[15:8];
      2'd2:    byte_lane = rdata_q[23:16];
      default: byte_lane = rdata_q[31:24];
    endcase
    case (load_size_q)
      2'b00: begin
        load_val     = load_uns_q ? {{(DATA_W-8){1'b0}}, byte_lane}
                                  : {{(DATA_W-8){byte_lane[7]}}, byte_lane};
        misalign_det = 1'b0;
      end
      2'b01: begin
        load_val     = load_uns_q ? {{(DATA_W-16){1'b0}}, half_lane}
                                  : {{(DATA_W-16){half_lane[15]}}, half_lane};
        misalign_det = is_load & offset[0];
      end
      default: begin
        load_val     = rdata_q;
        misalign_det = is_load & (offset != 2'b00);
      end
    endcase
  end

  // Result select and write gating; a write to r0 is never issued.
  always_comb begin
    case (result_src_q)
      2'b00:   ResultW = alu_q;
      2'b01:   ResultW = load_val;
      2'b10:   ResultW = pc4_q;
      default: ResultW = imm_q;
    endcase
    RdW        = rd_q;
    ValidW     = valid_q;
    busy_o     = (state_q == S_WAIT);
    misalign_o = valid_q & misalign_det;
    RegWriteW  = valid_q & reg_write_q & (rd_q != '0) & (state_q == S_RUN) & ~misalign_det;
  end

`ifdef WB_RETIRE_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Count every RUN cycle holding a valid, well-aligned instruction.
  always_comb begin
    cnt_d = cnt_q;
    if (valid_q && (state_q == S_RUN) && !misalign_det) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Retire counter flop, wraps naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign retired_cnt_o = cnt_q;
`else
  assign retired_cnt_o = {CNT_W{1'b0}};
`endif

endmodule
